// File: rtl/cap_pkg.sv
// rtl/cap_pkg.sv - capture FSM state type, sizes and SUMP opcodes shared with the command decoder
package cap_pkg;

  localparam int CAP_DEPTH  = 8192;
  localparam int CAP_ADDR_W = 13;
  localparam int CAP_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DONE  = 2'd3
  } cap_state_t;

  localparam logic [7:0] SUMP_RESET      = 8'h00;
  localparam logic [7:0] SUMP_RUN        = 8'h01;
  localparam logic [7:0] SUMP_ID         = 8'h02;
  localparam logic [7:0] SUMP_SET_DIV    = 8'h80;
  localparam logic [7:0] SUMP_SET_CNT    = 8'h81;
  localparam logic [7:0] SUMP_SET_FLAGS  = 8'h82;
  localparam logic [7:0] SUMP_TRIG_MASK  = 8'hC0;
  localparam logic [7:0] SUMP_TRIG_VALUE = 8'hC1;
  localparam logic [7:0] SUMP_TRIG_CFG   = 8'hC2;

endpackage

// File: rtl/cap_trig_match.sv
// rtl/cap_trig_match.sv - mask/value trigger comparator latched at arm
// CAP_SAMPLER_EDGE_EN adds edge mode and the previous-sample register
module cap_trig_match
  import cap_pkg::*;
#(
  parameter int DATA_W = CAP_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_mask,
  input  logic [DATA_W-1:0] i_value,
`ifdef CAP_SAMPLER_EDGE_EN
  input  logic              i_edge,
  input  logic              i_advance,
`endif
  input  logic [DATA_W-1:0] i_sample,
  output logic              o_hit
);

  logic [DATA_W-1:0] r_mask;
  logic [DATA_W-1:0] r_value;
  logic              w_level_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mask  <= '0;
      r_value <= '0;
    end else if (i_load) begin
      r_mask  <= i_mask;
      r_value <= i_value;
    end
  end

  assign w_level_hit = (((i_sample ^ r_value) & r_mask) == '0);

`ifdef CAP_SAMPLER_EDGE_EN
  logic              r_edge;
  logic              r_prev_vld;
  logic [DATA_W-1:0] r_prev;
  logic              w_edge_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_edge     <= 1'b0;
      r_prev_vld <= 1'b0;
      r_prev     <= '0;
    end else if (i_load) begin
      r_edge     <= i_edge;
      r_prev_vld <= 1'b0;
    end else if (i_advance) begin
      r_prev     <= i_sample;
      r_prev_vld <= 1'b1;
    end
  end

  // Each masked channel must now equal the value and previously have differed from it.
  assign w_edge_hit = r_prev_vld ?
      ((((i_sample ^ r_value) | ~(r_prev ^ r_value)) & r_mask) == '0) :
      (r_mask == '0);

  assign o_hit = r_edge ? w_edge_hit : w_level_hit;
`else
  assign o_hit = w_level_hit;
`endif

endmodule

// File: rtl/cap_sampler.sv
// rtl/cap_sampler.sv - probe synchroniser, SUMP divider and ring-buffer capture into BRAM
// CAP_SAMPLER_EDGE_EN adds the trig_edge input and edge-triggered mode
module cap_sampler
  import cap_pkg::*;
#(
  parameter int ADDR_W      = CAP_ADDR_W,
  parameter int DATA_W      = CAP_DATA_W,
  parameter int DIV_W       = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic              CAP_CLK,
  input  logic              CAP_RST_N,
  input  logic [DATA_W-1:0] CAP,
  input  logic              arm,
  input  logic              abort,
`ifdef CAP_SAMPLER_EDGE_EN
  input  logic              trig_edge,
`endif
  input  logic [DIV_W-1:0]  cap_div,
  input  logic [DATA_W-1:0] trig_mask,
  input  logic [DATA_W-1:0] trig_value,
  input  logic [ADDR_W-1:0] post_count,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              triggered,
  output logic [ADDR_W-1:0] trig_addr,
  output logic              wrapped,
  output logic              done
);

  localparam logic [1:0] S_IDLE  = 2'(IDLE);
  localparam logic [1:0] S_ARMED = 2'(ARMED);
  localparam logic [1:0] S_POST  = 2'(POST);
  localparam logic [1:0] S_DONE  = 2'(DONE);

  logic [DATA_W-1:0] r_sync [SYNC_STAGES];
  logic [1:0]        r_state;
  logic [DIV_W-1:0]  r_div;
  logic [DIV_W-1:0]  r_div_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_post;
  logic [ADDR_W-1:0] r_post_cnt;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic              r_triggered;
  logic [ADDR_W-1:0] r_trig_addr;
  logic              r_wrapped;
  logic              r_done;

  logic [DATA_W-1:0] w_sample;
  logic              w_running;
  logic              w_strobe;
  logic              w_arm_go;
  logic              w_hit;

  always_ff @(posedge CAP_CLK or negedge CAP_RST_N) begin
    if (!CAP_RST_N) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= CAP;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign w_sample  = r_sync[SYNC_STAGES-1];
  assign w_running = (r_state == S_ARMED) || (r_state == S_POST);
  assign w_strobe  = w_running && (r_div_cnt == r_div) && !abort;
  assign w_arm_go  = (r_state == S_IDLE) && arm && !abort;

  cap_trig_match #(.DATA_W(DATA_W)) u_trig (
    .clk       (CAP_CLK),
    .rst_n     (CAP_RST_N),
    .i_load    (w_arm_go),
    .i_mask    (trig_mask),
    .i_value   (trig_value),
`ifdef CAP_SAMPLER_EDGE_EN
    .i_edge    (trig_edge),
    .i_advance (w_strobe),
`endif
    .i_sample  (w_sample),
    .o_hit     (w_hit)
  );

  always_ff @(posedge CAP_CLK or negedge CAP_RST_N) begin
    if (!CAP_RST_N) begin
      r_state     <= S_IDLE;
      r_div       <= '0;
      r_div_cnt   <= '0;
      r_addr      <= '0;
      r_post      <= '0;
      r_post_cnt  <= '0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_triggered <= 1'b0;
      r_trig_addr <= '0;
      r_wrapped   <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_wr_en <= w_strobe;
      r_done  <= (r_state == S_DONE) && !abort;

      if (w_running) r_div_cnt <= (r_div_cnt == r_div) ? '0 : r_div_cnt + DIV_W'(1);

      if (w_strobe) begin
        r_wr_addr <= r_addr;
        r_wr_data <= w_sample;
        r_addr    <= r_addr + ADDR_W'(1);
        if (&r_addr) r_wrapped <= 1'b1;
      end

      if (abort) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: if (arm) begin
            r_state     <= S_ARMED;
            r_addr      <= '0;
            r_wr_addr   <= '0;
            r_div_cnt   <= '0;
            r_div       <= cap_div;
            r_post      <= post_count;
            r_triggered <= 1'b0;
            r_trig_addr <= '0;
            r_wrapped   <= 1'b0;
          end
          S_ARMED: if (w_strobe && w_hit) begin
            r_triggered <= 1'b1;
            r_trig_addr <= r_addr;
            r_post_cnt  <= r_post;
            r_state     <= (r_post == '0) ? S_DONE : S_POST;
          end
          S_POST: if (w_strobe) begin
            r_post_cnt <= r_post_cnt - ADDR_W'(1);
            if (r_post_cnt == ADDR_W'(1)) r_state <= S_DONE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // DONE covers the final write cycle, so busy drops exactly as the done pulse appears.
  assign busy      = (r_state != S_IDLE);
  assign wr_en     = r_wr_en;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign triggered = r_triggered;
  assign trig_addr = r_trig_addr;
  assign wrapped   = r_wrapped;
  assign done      = r_done;

endmodule

// File: tb/tb_cap_sampler.sv
// tb/tb_cap_sampler.sv - directed vector bench for cap_sampler
module tb_cap_sampler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  cap = 8'h00;
  logic        arm = 1'b0;
  logic        abort = 1'b0;
  logic [23:0] cap_div = '0;
  logic [7:0]  trig_mask = '0;
  logic [7:0]  trig_value = '0;
  logic [12:0] post_count = '0;
`ifdef CAP_SAMPLER_EDGE_EN
  logic        trig_edge = 1'b0;
`endif
  logic        wr_en;
  logic [12:0] wr_addr;
  logic [7:0]  wr_data;
  logic        busy;
  logic        triggered;
  logic [12:0] trig_addr;
  logic        wrapped;
  logic        done;

  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  cap_sampler dut (
    .CAP_CLK    (clk),
    .CAP_RST_N  (rst_n),
    .CAP        (cap),
    .arm        (arm),
    .abort      (abort),
`ifdef CAP_SAMPLER_EDGE_EN
    .trig_edge  (trig_edge),
`endif
    .cap_div    (cap_div),
    .trig_mask  (trig_mask),
    .trig_value (trig_value),
    .post_count (post_count),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .triggered  (triggered),
    .trig_addr  (trig_addr),
    .wrapped    (wrapped),
    .done       (done)
  );

  typedef struct {
    logic [23:0] div;
    logic [7:0]  mask;
    logic [7:0]  value;
    logic [12:0] post;
    int          chg_n;
    logic [7:0]  old_cap;
    logic [7:0]  new_cap;
    int          trig_n;
    int          exp_writes;
    logic [12:0] exp_trig_addr;
    logic [12:0] exp_last_addr;
    logic        exp_wrapped;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
  endtask

  task automatic setup(input vec_t v);
    cap        = v.old_cap;
    cap_div    = v.div;
    trig_mask  = v.mask;
    trig_value = v.value;
    post_count = v.post;
    repeat (3) @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int  c, nwr, last_c, per, budget, extra;
    int  e_addr, e_data, e_space, e_trig, e_busy;
    bit  done_seen;
    logic [7:0] ed;
    setup(v);
    pulse_arm();
    per = int'(v.div) + 1;
    budget = per * (v.exp_writes + 4) + 20;
    c = 0; nwr = 0; last_c = 0; done_seen = 0;
    e_addr = 0; e_data = 0; e_space = 0; e_trig = 0; e_busy = 0;
    while (!done_seen && c < budget) begin
      if (wr_en) begin
        if (wr_addr != 13'(nwr)) e_addr++;
        ed = (v.chg_n > 0 && nwr >= v.chg_n) ? v.new_cap : v.old_cap;
        if (wr_data != ed) e_data++;
        if (c - last_c != per) e_space++;
        if (triggered != (nwr >= v.trig_n)) e_trig++;
        if (!busy) e_busy++;
        last_c = c;
        nwr++;
      end
      if (done) begin
        done_seen = 1;
        check({tag, " done_latency"}, c - last_c, 1);
        check({tag, " busy_at_done"}, int'(busy), 0);
      end else begin
        if (v.chg_n > 0 && c == per * v.chg_n - 2) cap = v.new_cap;
        @(negedge clk);
        c++;
      end
    end
    check({tag, " done_seen"}, int'(done_seen), 1);
    check({tag, " write_count"}, nwr, v.exp_writes);
    check({tag, " trig_addr"}, int'(trig_addr), int'(v.exp_trig_addr));
    check({tag, " triggered"}, int'(triggered), 1);
    check({tag, " wrapped"}, int'(wrapped), int'(v.exp_wrapped));
    check({tag, " last_wr_addr"}, int'(wr_addr), int'(v.exp_last_addr));
    check({tag, " addr_seq_errors"}, e_addr, 0);
    check({tag, " data_errors"}, e_data, 0);
    check({tag, " spacing_errors"}, e_space, 0);
    check({tag, " triggered_timing_errors"}, e_trig, 0);
    check({tag, " busy_during_write_errors"}, e_busy, 0);
    @(negedge clk);
    check({tag, " done_one_cycle"}, int'(done), 0);
    extra = 0;
    repeat (6) begin
      if (wr_en) extra++;
      @(negedge clk);
    end
    check({tag, " no_writes_after_done"}, extra, 0);
  endtask

  initial begin
    int n, c, extra;
    vec_t v;

    vecs[0] = '{24'd0, 8'h00, 8'h00, 13'd15, 0,    8'h5A, 8'h5A, 0,    16,   13'd0,   13'd15,  1'b0};
    vecs[1] = '{24'd3, 8'h01, 8'h01, 13'd4,  20,   8'h00, 8'h01, 20,   25,   13'd20,  13'd24,  1'b0};
    vecs[2] = '{24'd0, 8'h80, 8'h80, 13'd10, 9000, 8'h00, 8'h80, 9000, 9011, 13'd808, 13'd818, 1'b1};
    vecs[3] = '{24'd1, 8'h0F, 8'h05, 13'd0,  5,    8'hF0, 8'h35, 5,    6,    13'd5,   13'd5,   1'b0};

    repeat (2) @(negedge clk);
    check("reset wr_en", int'(wr_en), 0);
    check("reset outputs", int'({busy, triggered, wrapped, done}), 0);
    check("reset wr_addr", int'(wr_addr), 0);
    check("reset trig_addr", int'(trig_addr), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle after reset busy", int'(busy), 0);

    for (int i = 0; i < 4; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // abort while in POST: no done, no further writes, trigger results held
    v = '{24'd0, 8'h00, 8'h00, 13'd200, 0, 8'h3C, 8'h3C, 0, 0, 13'd0, 13'd0, 1'b0};
    setup(v);
    pulse_arm();
    check("abort busy_after_arm", int'(busy), 1);
    n = 0; c = 0;
    while (n < 100 && c < 300) begin
      @(negedge clk);
      c++;
      if (wr_en) n++;
    end
    check("abort pre_writes", n, 100);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort busy_low", int'(busy), 0);
    extra = 0;
    repeat (20) begin
      if (wr_en || done) extra++;
      @(negedge clk);
    end
    check("abort no_wr_or_done", extra, 0);
    check("abort triggered_held", int'(triggered), 1);
    run_vec('{24'd2, 8'h00, 8'h00, 13'd3, 0, 8'hA5, 8'hA5, 0, 4, 13'd0, 13'd3, 1'b0}, "rearm");

    // arm while ARMED is ignored; arm+abort together ends in IDLE
    v = '{24'd0, 8'h01, 8'h01, 13'd3, 0, 8'h00, 8'h00, 0, 0, 13'd0, 13'd0, 1'b0};
    setup(v);
    pulse_arm();
    n = 0; c = 0;
    while (n < 10 && c < 100) begin
      @(negedge clk);
      c++;
      if (wr_en) n++;
    end
    check("rearm_ignored pre_writes", n, 10);
    pulse_arm();
    check("rearm_ignored addr10", int'(wr_addr), 10);
    @(negedge clk);
    check("rearm_ignored addr11", int'(wr_addr), 11);
    check("rearm_ignored busy", int'(busy), 1);
    arm = 1'b1; abort = 1'b1;
    @(negedge clk);
    arm = 1'b0; abort = 1'b0;
    check("arm_abort armed busy", int'(busy), 0);
    arm = 1'b1; abort = 1'b1;
    @(negedge clk);
    arm = 1'b0; abort = 1'b0;
    check("arm_abort idle busy", int'(busy), 0);
    extra = 0;
    repeat (5) begin
      if (wr_en) extra++;
      @(negedge clk);
    end
    check("arm_abort idle no_writes", extra, 0);

`ifdef CAP_SAMPLER_EDGE_EN
    trig_edge = 1'b1;
    run_vec('{24'd0, 8'h02, 8'h00, 13'd3, 7, 8'h02, 8'h00, 7, 11, 13'd7, 13'd10, 1'b0}, "edge");
    trig_edge = 1'b0;
`endif

    // asynchronous reset mid-capture clears outputs without a clock edge
    v = '{24'd0, 8'h00, 8'h00, 13'd500, 0, 8'hFF, 8'hFF, 0, 0, 13'd0, 13'd0, 1'b0};
    setup(v);
    pulse_arm();
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset flags", int'({wr_en, busy, triggered, wrapped, done}), 0);
    check("midreset wr_addr", int'(wr_addr), 0);
    check("midreset wr_data", int'(wr_data), 0);
    check("midreset trig_addr", int'(trig_addr), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
